// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_D    = 2'd2
    } rsp_st_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Fetch starvation counter: counts consecutive fetch denials and requests a forced fetch grant.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic if_gnt,
    output logic force_if
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Next count: clear on grant or idle fetch, otherwise count up to saturation
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (if_gnt || !if_req) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_r == MAX_C) begin
            cnt_nxt_s = cnt_r;
        end else begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign force_if = (cnt_r == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one synchronous-read memory between instruction fetch and load/store.
// Optional fetch anti-starvation is enabled by defining ARB_FAIR_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_stall,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W/8-1:0]   d_we,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  m_en,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W/8-1:0]   m_we,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W-1:0]     m_rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("STARVE_MAX must be in 1..15");
    end

    owner_e  owner_s;
    rsp_st_e rsp_st_r;
    rsp_st_e rsp_nxt_s;
    logic    force_if_s;

`ifdef ARB_FAIR_EN
    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_gnt   (if_gnt),
        .force_if (force_if_s)
    );
`else
    assign force_if_s = 1'b0;
`endif

    // Grant selection: data first unless fetch has starved long enough
    always_comb begin
        owner_s = OWN_NONE;
        if (reset) begin
            owner_s = OWN_NONE;
        end else if (d_req && !(force_if_s && if_req)) begin
            owner_s = OWN_D;
        end else if (if_req) begin
            owner_s = OWN_IF;
        end else begin
            owner_s = OWN_NONE;
        end
    end

    assign if_gnt   = (owner_s == OWN_IF);
    assign d_gnt    = (owner_s == OWN_D);
    assign if_stall = !reset && if_req && !if_gnt;

    // Memory drive from the granted owner; response routing for next cycle
    always_comb begin
        m_en      = 1'b0;
        m_addr    = {ADDR_W{1'b0}};
        m_we      = {BE_W{1'b0}};
        m_wdata   = {DATA_W{1'b0}};
        rsp_nxt_s = RSP_NONE;
        case (owner_s)
            OWN_IF: begin
                m_en      = 1'b1;
                m_addr    = if_addr & WORD_MASK;
                rsp_nxt_s = RSP_IF;
            end
            OWN_D: begin
                m_en      = 1'b1;
                m_addr    = d_addr & WORD_MASK;
                m_we      = d_we;
                m_wdata   = d_wdata;
                rsp_nxt_s = (d_we == {BE_W{1'b0}}) ? RSP_D : RSP_NONE;
            end
            default: begin
                m_en      = 1'b0;
                rsp_nxt_s = RSP_NONE;
            end
        endcase
    end

    // Response state register
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_st_r <= RSP_NONE;
        end else begin
            rsp_st_r <= rsp_nxt_s;
        end
    end

    // Read-data return; a reset in the response cycle drops the pending response
    always_comb begin
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = {DATA_W{1'b0}};
        d_rdata   = {DATA_W{1'b0}};
        case (rsp_st_r)
            RSP_IF: begin
                if (!reset) begin
                    if_rvalid = 1'b1;
                    if_rdata  = m_rdata;
                end else begin
                    if_rvalid = 1'b0;
                end
            end
            RSP_D: begin
                if (!reset) begin
                    d_rvalid = 1'b1;
                    d_rdata  = m_rdata;
                end else begin
                    d_rvalid = 1'b0;
                end
            end
            default: begin
                if_rvalid = 1'b0;
                d_rvalid  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, synchronous-read memory between the instruction-fetch path (`imem_io_ports` side) and the load/store path (`dmem_io_ports` side) of the 5-stage RV32I core. It grants at most one access per cycle, routes the one-cycle-late read data back to the requester that issued it, and raises a fetch stall toward the pipeline whenever fetch is denied. It sits between the core's IF/MEM stages and the unified memory model.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `DATA_W`, default 32: data width; the byte-enable width is `DATA_W/8`.
- `STARVE_MAX`, default 4: consecutive fetch denials before fetch is forced. Used only with `ARB_FAIR_EN`. Legal range is 1..15.

- `clk`  in  1  the only clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `if_req`  in  1  fetch request.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_gnt`  out  1  fetch granted this cycle (combinational).
- `if_stall`  out  1  `if_req & ~if_gnt`; the IF stage holds the PC.
- `if_rvalid`  out  1  `if_rdata` is valid (registered).
- `if_rdata`  out  DATA_W  fetched instruction.
- `d_req`  in  1  data request.
- `d_addr`  in  ADDR_W  data byte address.
- `d_we`  in  DATA_W/8  byte write enables; 0 means read.
- `d_wdata`  in  DATA_W  store data, already lane-replicated.
- `d_gnt`  out  1  data granted this cycle (combinational).
- `d_rvalid`  out  1  load data valid (registered).
- `d_rdata`  out  DATA_W  load data.
- `m_en`  out  1  memory access strobe.
- `m_addr`  out  ADDR_W  granted address with bits [1:0] forced to 0.
- `m_we`  out  DATA_W/8  byte enables; 0 for reads.
- `m_wdata`  out  DATA_W  write data.
- `m_rdata`  in  DATA_W  read data, valid one cycle after a read strobe.

## Operation
- **Grant selection:** each cycle the arbiter grants exactly one requester, or none if neither requests.
  - Default priority is data over fetch.
  - With `ARB_FAIR_EN`, fetch wins when `force_if` is set.
  - The grant is combinational from `*_req` and registered state only. Grant never depends on `m_rdata`.
- **Memory drive:** the `m_*` outputs are driven from the granted requester.
  - `m_en = if_gnt | d_gnt`.
  - Fetch is always a read: `m_we = 0`.
- **Requester rule:** a requester holds `req`, `addr`, `we` and `wdata` stable until it sees `gnt`. A request dropped before grant is ignored, and the arbiter keeps no record of it.
- **Response FSM:** state `rsp_st` takes values RSP_NONE, RSP_IF, RSP_D.
  - On a granted read, the next state is RSP_IF or RSP_D according to the owner.
  - On a granted write, or no grant, the next state is RSP_NONE.
  - In RSP_IF: `if_rvalid = 1` and `if_rdata = m_rdata`.
  - In RSP_D: `d_rvalid = 1` and `d_rdata = m_rdata`.
  - Otherwise both rvalids are 0, and both rdata outputs are 0.
- **Pipelining:** back-to-back grants are allowed every cycle. The response for the access granted in cycle N appears in cycle N+1, while a new access is granted in cycle N+1.
- **Stores:** a store produces no rvalid.
- **Address:** `m_addr` is always word-aligned. Misalignment is not checked.

## Timing
- Grant-to-memory latency is 0 cycles. Grant-to-rvalid latency is 1 cycle, for reads only.
- **Reset values:**
  - `rsp_st = RSP_NONE`, so `if_rvalid = d_rvalid = 0` and both rdata outputs are 0.
  - The starvation counter is 0.
  - While `reset` is high, all grants are 0, `m_en = 0`, `m_addr = 0`, `m_we = 0`, `m_wdata = 0`, and `if_stall = 0`.
- **Reset mid-read:** if `reset` is asserted in the cycle after a read grant, rvalid is 0 in that cycle. The response is lost and is not replayed.
- **Simultaneous requests:** `d_gnt = 1` and `if_stall = 1`, unless fairness forces fetch. In that case `if_gnt = 1` and `d_gnt = 0`; the data requester waits, and no data stall output is generated here.
- **Continuous requests:** both rvalids can never be 1 in the same cycle.

## Configuration
- **`ARB_FAIR_EN` defined:**
  - A 4-bit counter increments on each cycle with `if_req & ~if_gnt` and clears on `if_gnt`, or on any cycle without `if_req`. It saturates at `STARVE_MAX`.
  - `force_if = (cnt == STARVE_MAX)`.
- **`ARB_FAIR_EN` undefined:**
  - There is no counter and data priority is strict. A continuous `d_req` starves fetch indefinitely.

## Structure
- **Package `mem_arb_pkg`:**
  - enum `rsp_st_e` {RSP_NONE, RSP_IF, RSP_D}.
  - enum `owner_e` {OWN_NONE, OWN_IF, OWN_D}.
  - localparam for the counter width (4).
- **Sub-module `arb_starve_ctr`** (counter plus `force_if` compare): instantiated only under `ARB_FAIR_EN`.

## Test plan
- Fetch-only reads to 0x0, 0x4, 0x8 on consecutive cycles → `if_gnt` every cycle; `if_rvalid` one cycle later with the matching words; `if_stall = 0` throughout.
- `if_req` and `d_req` reading 0x100 in the same cycle → `d_gnt = 1`, `if_stall = 1`; `d_rdata = mem[0x100]` next cycle; fetch granted the following cycle.
- Store `d_we = 4'b0011`, `d_wdata = 0xAAAABBBB` to 0x20, then a load from 0x20 → no rvalid after the store; the load returns the low halfword as 0xBBBB with the upper bytes unchanged.
- Reset asserted the cycle after a fetch read grant → `if_rvalid = 0` that cycle; `m_en = 0` and all outputs at their reset values while `reset` is high.
- With `ARB_FAIR_EN` and `STARVE_MAX = 4`: `d_req` and `if_req` held high → 4 data grants, then 1 fetch grant, repeating.
- Without `ARB_FAIR_EN`, the same stimulus → `if_gnt` is never asserted.
- Unaligned `d_addr = 0x23` → `m_addr = 0x20`.
